stopwatch_display_scan: RTL
===========================

Name: stopwatch_display_scan

Overview:
Consumer end of the stopwatch clock divider. Takes the divider's fast scan tick and blink tick as single-cycle enables on the system clock, and time-multiplexes four BCD digits (MM:SS) onto a 4-anode, active-low 7-segment display. Holds a per-frame digit snapshot and inserts anode dead-time between digits. When adjust mode is active, blinks the selected digit pair.

Parameters:
DEAD_CYCLES, 1, clk cycles with all anodes off between consecutive digits; legal range 1..255 (8-bit counter).

Ports:
clk  input  1  system clock (only clock)
rst  input  1  synchronous, active-high reset
scan_tick  input  1  one-cycle pulse from divider fast output; advances scan
blink_tick  input  1  one-cycle pulse from divider blink output; toggles blink phase
adjust  input  1  1 = adjust mode, blinking enabled
sel  input  1  blink target: 0 = minutes (digits 3,2), 1 = seconds (digits 1,0)
digits  input  16  BCD {min_tens, min_ones, sec_tens, sec_ones}; [15:12] = digit 3
an  output  4  anode enables, active low; an[i] drives digit i
seg  output  8  {dp,g,f,e,d,c,b,a}, active low

Behaviour:
- Reset is synchronous, active-high, clk only; applies mid-operation on the next edge.
- Reset values: an=4'b1111, seg=8'hFF, state=BLANK, idx=3, dead_cnt=DEAD_CYCLES-1, blink_ph=0, snapshot=16'h0000.
- All outputs are registered; no combinational path from inputs to an or seg.
- States: DRIVE and BLANK.
- DRIVE:
  - an has exactly one zero, at bit idx; seg shows the decoded snapshot digit idx.
  - On scan_tick: next edge goes to BLANK, an=1111, seg=FF, dead_cnt=DEAD_CYCLES-1.
- BLANK:
  - an=1111. scan_tick is ignored (dropped, not queued).
  - When dead_cnt==0: next edge sets idx=(idx+1) mod 4, enters DRIVE, loads an and seg for the new idx.
  - Otherwise dead_cnt decrements.
- Snapshot: on the BLANK->DRIVE edge where new idx==0, snapshot<=digits. The digits used for that load come from the new snapshot.
- First frame after reset: BLANK for DEAD_CYCLES cycles, then digit 0 with a fresh snapshot. Scan order is 0,1,2,3,0,...
- Decode (active low, a..g): 0..9 standard 7-seg; values 10..15 show dash only (g lit, seg[6:0]=7'b0111111).
- Blink phase:
  - While adjust=0: blink_ph forced to 0.
  - While adjust=1: blink_ph toggles on each blink_tick.
- Blanking: if adjust=1 and blink_ph=1 when a digit is loaded, and that digit is in the sel pair, then seg=8'hFF. The anode is still driven.
- adjust, sel and blink_ph are sampled only at the DRIVE-load edge. Changes take effect from the next digit.
- Simultaneous events:
  - scan_tick and blink_tick in the same cycle are processed independently.
  - rst wins over everything.
  - scan_tick in the same cycle as the BLANK->DRIVE transition is ignored.
- seg[7] (dp) = 1 (off) unless the optional feature is enabled.

Optional Feature:
Macro STOPWATCH_DP_EN.
- Defined: dp is lit (seg[7]=0) while digit 2 (minute ones) is driven and not blink-blanked, giving the MM.SS separator.
- Undefined: seg[7] is constantly 1. No extra logic.

Test Plan:
- Reset then idle, DEAD_CYCLES=1, digits=16'h1234 -> an=1111 for 1 cycle after rst release, then an=1110 with seg=8'b1001_1001 (digit "4"); stays until scan_tick.
- Four scan_ticks spaced 10 cycles -> an sequence 1110,1101,1011,0111, each preceded by exactly DEAD_CYCLES cycles of 1111; digits "4","3","2","1".
- Change digits to 16'h5678 while idx=2 -> digits 2 and 3 still show "2","1"; after wrap, digit 0 shows "8".
- adjust=1, sel=1, one blink_tick -> next loads of digits 0 and 1 have seg=FF and anode low; digits 2 and 3 normal. A second blink_tick restores them. Dropping adjust clears blink_ph.
- digits=16'hAF09 -> digits 3 and 2 show dash (seg=8'hBF); scan_tick during BLANK with DEAD_CYCLES=4 is ignored, so idx advances only once.
- rst asserted while in DRIVE at idx=2 -> next edge an=1111, seg=FF, blink_ph=0; with STOPWATCH_DP_EN, digit 2 shows seg[7]=0.

Source files
------------

// File: rtl/stopwatch_display_scan.sv
// Four-digit MM:SS scanner for a 4-anode, active-low 7-segment display, with dead-time and blink.
// Optional build macro STOPWATCH_DP_EN lights the decimal point on digit 2 as the MM.SS separator.
module stopwatch_display_scan #(
   parameter int unsigned DEAD_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scan_tick,
   input  logic        blink_tick,
   input  logic        adjust,
   input  logic        sel,
   input  logic [15:0] digits,
   output logic [3:0]  an,
   output logic [7:0]  seg
);

   typedef enum logic [0:0] {
      StDrive,
      StBlank
   } state_e;

   localparam logic [7:0] DeadInit = 8'(DEAD_CYCLES - 1);

   state_e      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [7:0]  dead_cnt_q, dead_cnt_d;
   logic        blink_ph_q, blink_ph_d;
   logic [15:0] snap_q, snap_d;
   logic [3:0]  an_q, an_d;
   logic [7:0]  seg_q, seg_d;

   logic [3:0]  cur_digit;
   logic        blank_dig;
   logic        dp_n;

   // Active-low {g,f,e,d,c,b,a}; non-BCD values show a lone dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] val);
      logic [6:0] s;
      case (val)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      dead_cnt_d = dead_cnt_q;
      snap_d     = snap_q;
      an_d       = an_q;
      seg_d      = seg_q;
      cur_digit  = 4'h0;
      blank_dig  = 1'b0;
      dp_n       = 1'b1;

      blink_ph_d = adjust ? (blink_ph_q ^ blink_tick) : 1'b0;

      case (state_q)
         StDrive: begin
            if (scan_tick) begin
               state_d    = StBlank;
               an_d       = 4'hF;
               seg_d      = 8'hFF;
               dead_cnt_d = DeadInit;
            end
         end
         StBlank: begin
            an_d  = 4'hF;
            seg_d = 8'hFF;
            if (dead_cnt_q == 8'd0) begin
               state_d = StDrive;
               idx_d   = idx_q + 2'd1;
               // Snapshot is taken at frame start so the digit 0 load already uses it.
               if (idx_d == 2'd0) begin
                  snap_d = digits;
               end
               cur_digit = snap_d[{idx_d, 2'b00} +: 4];
               blank_dig = adjust && blink_ph_q && (idx_d[1] == ~sel);
`ifdef STOPWATCH_DP_EN
               dp_n = (idx_d != 2'd2);
`else
               dp_n = 1'b1;
`endif
               an_d  = ~(4'b0001 << idx_d);
               seg_d = blank_dig ? 8'hFF : {dp_n, seg_decode(cur_digit)};
            end else begin
               dead_cnt_d = dead_cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = StBlank;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StBlank;
         idx_q      <= 2'd3;
         dead_cnt_q <= DeadInit;
         blink_ph_q <= 1'b0;
         snap_q     <= 16'h0000;
         an_q       <= 4'hF;
         seg_q      <= 8'hFF;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         dead_cnt_q <= dead_cnt_d;
         blink_ph_q <= blink_ph_d;
         snap_q     <= snap_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;

endmodule
